memory_port_arbiter: RTL and testbench

- Shares one memory port between two requesters: instruction fetch (read-only) and data load/store.
- Sits between the hart's stage logic and the unified memory/MMIO block. It serialises accesses, holds each granted request stable until the memory acks, and returns a registered one-cycle response to the requester that won.
- Round-robin fairness under contention; an ack watchdog bounds MMIO writes that never complete.

---
 rtl/memory_port_arbiter_pkg.sv | 29 ++
 rtl/memory_port_arbiter_watchdog.sv | 28 ++
 rtl/memory_port_arbiter.sv | 126 ++++++++++++
 tb/tb_memory_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_port_arbiter_pkg.sv
// rtl/memory_port_arbiter_pkg.sv - shared types for the fetch/data memory port arbiter
package memory_port_arbiter_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    write_byte,
    write_half,
    write_word
  } write_width_t;

  typedef struct packed {
    logic              enable;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   data;
    write_width_t      width;
  } mem_write_control_t;

  typedef enum logic {
    ARB_PORT_FETCH,
    ARB_PORT_DATA
  } arb_port_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

endpackage

// File: rtl/memory_port_arbiter_watchdog.sv
// rtl/memory_port_arbiter_watchdog.sv - ack watchdog counting busy cycles without mem_ack
module arb_watchdog_counter #(
  parameter int ack_timeout   = 1024,
  parameter int counter_width = 11
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [counter_width-1:0] last_count = counter_width'(ack_timeout - 1);

  logic [counter_width-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  // Gated by enable so an ack in the final cycle suppresses expiry.
  assign expired = enable && (count == last_count);

endmodule

// File: rtl/memory_port_arbiter.sv
// rtl/memory_port_arbiter.sv - round-robin arbiter sharing one memory port between fetch and data
module memory_port_arbiter
  import memory_port_arbiter_pkg::*;
#(
  parameter int ack_timeout   = 1024,
  parameter int counter_width = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req_valid,
  input  logic [XLEN-1:0]   if_req_addr,
  output logic              if_req_accept,
  output logic              if_resp_valid,
  output logic [XLEN-1:0]   if_resp_data,
  input  logic              d_req_valid,
  input  logic [XLEN-1:0]   d_req_addr,
  input  logic              d_req_w_enable,
  input  logic [XLEN-1:0]   d_req_w_data,
  input  write_width_t      d_req_w_width,
  output logic              d_req_accept,
  output logic              d_resp_valid,
  output logic [XLEN-1:0]   d_resp_data,
  output logic              d_resp_error,
  output logic              mem_req,
  output logic [XLEN-1:0]   mem_addr,
  output logic              mem_w_enable,
  output logic [XLEN-1:0]   mem_w_data,
  output write_width_t      mem_w_width,
  input  logic [XLEN-1:0]   mem_r_data,
  input  logic              mem_ack
);

  arb_state_t          state, next_state;
  arb_port_t           last_grant, grant_port;
  mem_write_control_t  latched, grant_ctrl;
  logic                if_eligible, d_eligible;
  logic                accept, complete, expired;
  logic [XLEN-1:0]     resp_word;

  // A port still showing its response pulse is holding a stale request.
  assign if_eligible = if_req_valid && !if_resp_valid;
  assign d_eligible  = d_req_valid && !d_resp_valid;
  assign accept      = if_req_accept || d_req_accept;
  assign complete    = (state == ARB_BUSY) && (mem_ack || expired);
  assign resp_word   = (mem_ack && !latched.enable) ? mem_r_data : '0;

  always_comb begin
    next_state    = state;
    if_req_accept = 1'b0;
    d_req_accept  = 1'b0;
    grant_port    = last_grant;
    grant_ctrl    = latched;
    case (state)
      ARB_IDLE: begin
        if (if_eligible && (!d_eligible || last_grant == ARB_PORT_DATA)) begin
          if_req_accept = 1'b1;
          grant_port    = ARB_PORT_FETCH;
          grant_ctrl    = '{enable: 1'b0, addr: if_req_addr, data: '0, width: write_word};
          next_state    = ARB_BUSY;
        end else if (d_eligible) begin
          d_req_accept = 1'b1;
          grant_port   = ARB_PORT_DATA;
          grant_ctrl   = '{enable: d_req_w_enable, addr: d_req_addr,
                           data: d_req_w_data, width: d_req_w_width};
          next_state   = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (complete) begin
          next_state = ARB_IDLE;
        end
      end
      default: next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ARB_IDLE;
      last_grant    <= ARB_PORT_DATA;
      latched       <= '{enable: 1'b0, addr: '0, data: '0, width: write_word};
      if_resp_valid <= 1'b0;
      if_resp_data  <= '0;
      d_resp_valid  <= 1'b0;
      d_resp_data   <= '0;
      d_resp_error  <= 1'b0;
    end else begin
      state         <= next_state;
      if_resp_valid <= 1'b0;
      d_resp_valid  <= 1'b0;
      d_resp_error  <= 1'b0;
      if (accept) begin
        latched    <= grant_ctrl;
        last_grant <= grant_port;
      end
      if (complete) begin
        if (last_grant == ARB_PORT_FETCH) begin
          if_resp_valid <= 1'b1;
          if_resp_data  <= resp_word;
        end else begin
          d_resp_valid <= 1'b1;
          d_resp_data  <= resp_word;
          d_resp_error <= !mem_ack;
        end
      end
    end
  end

  assign mem_req      = (state == ARB_BUSY);
  assign mem_addr     = latched.addr;
  assign mem_w_enable = mem_req && latched.enable;
  assign mem_w_data   = latched.data;
  assign mem_w_width  = latched.width;

  arb_watchdog_counter #(
    .ack_timeout   (ack_timeout),
    .counter_width (counter_width)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (accept),
    .enable  (mem_req && !mem_ack),
    .expired (expired)
  );

endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb/tb_memory_port_arbiter.sv - self-checking bench for memory_port_arbiter
module tb_memory_port_arbiter;
  import memory_port_arbiter_pkg::*;

  localparam int TIMEOUT = 16;

  logic clock, reset;
  logic if_req_valid, if_req_accept, if_resp_valid;
  logic [31:0] if_req_addr, if_resp_data;
  logic d_req_valid, d_req_w_enable, d_req_accept, d_resp_valid, d_resp_error;
  logic [31:0] d_req_addr, d_req_w_data, d_resp_data;
  write_width_t d_req_w_width, mem_w_width;
  logic mem_req, mem_w_enable, mem_ack;
  logic [31:0] mem_addr, mem_w_data, mem_r_data;

  memory_port_arbiter #(.ack_timeout(TIMEOUT), .counter_width(5)) dut (
    .clock(clock), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_accept(if_req_accept),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_w_enable(d_req_w_enable),
    .d_req_w_data(d_req_w_data), .d_req_w_width(d_req_w_width), .d_req_accept(d_req_accept),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_resp_error(d_resp_error),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_w_enable(mem_w_enable),
    .mem_w_data(mem_w_data), .mem_w_width(mem_w_width), .mem_r_data(mem_r_data),
    .mem_ack(mem_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic         is_data;
    logic [31:0]  addr;
    logic         wen;
    logic [31:0]  wdata;
    write_width_t width;
    int           delay;
    logic [31:0]  exp_data;
    logic         exp_err;
  } vec_t;

  typedef struct {
    arb_port_t   port;
    logic [31:0] data;
    logic        err;
    int          lat;
    int          acc_cyc;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t sb[$];
  arb_port_t glog[$];
  vec_t vecs[7];

  // memory responder controls and scoreboard expectations set by the stimulus
  bit ack_en = 1'b1;
  bit stray_ack = 1'b0;
  int ack_delay = 1;
  int busy_cnt = 0;
  logic [31:0] exp_if_data = '0;
  logic [31:0] exp_d_data = '0;

  logic [31:0] lat_addr, lat_wdata;
  logic lat_wen, lat_is_data;
  write_width_t lat_width;

  function automatic logic [31:0] rdata_for(input logic [31:0] a);
    return (a == 32'h0001_0000) ? 32'h0000_0013 : ~a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory model: acks after ack_delay busy cycles
  initial begin
    mem_ack = 1'b0;
    mem_r_data = '0;
    forever begin
      @(posedge clock); #1;
      busy_cnt   = mem_req ? busy_cnt + 1 : 0;
      mem_ack    = (ack_en && mem_req && busy_cnt >= ack_delay) || stray_ack;
      mem_r_data = rdata_for(mem_addr);
    end
  end

  // monitor: pops expectations on responses, pushes them on accepts
  initial begin
    exp_t e;
    forever begin
      @(posedge clock); #3;
      cyc++;
      if (!reset) begin
        if (mem_req) begin
          check("mem_addr_stable", mem_addr, lat_addr);
          check("mem_w_enable_stable", {31'b0, mem_w_enable}, {31'b0, lat_wen});
          if (lat_is_data) begin
            check("mem_w_data_stable", mem_w_data, lat_wdata);
            check("mem_w_width_stable", 32'(mem_w_width), 32'(lat_width));
          end
        end
        if (if_resp_valid && d_resp_valid) check("dual_resp", 32'd1, 32'd0);
        if (d_resp_error && !d_resp_valid) check("error_without_valid", 32'd1, 32'd0);
        if (if_resp_valid || d_resp_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_resp", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("resp_port", {31'b0, d_resp_valid}, {31'b0, e.port == ARB_PORT_DATA});
            check("resp_data", d_resp_valid ? d_resp_data : if_resp_data, e.data);
            if (d_resp_valid) check("resp_error", {31'b0, d_resp_error}, {31'b0, e.err});
            check("resp_latency", cyc - e.acc_cyc, e.lat);
          end
        end
        if (if_req_accept && d_req_accept) check("dual_accept", 32'd1, 32'd0);
        if ((if_req_accept || d_req_accept) && mem_req) check("accept_in_busy", 32'd1, 32'd0);
        if (if_req_accept && if_resp_valid) check("stale_fetch_accept", 32'd1, 32'd0);
        if (d_req_accept && d_resp_valid) check("stale_data_accept", 32'd1, 32'd0);
        if (if_req_accept || d_req_accept) begin
          e.port    = if_req_accept ? ARB_PORT_FETCH : ARB_PORT_DATA;
          e.data    = ack_en ? (if_req_accept ? exp_if_data : exp_d_data) : 32'h0;
          e.err     = !ack_en && d_req_accept;
          e.lat     = ack_en ? ack_delay + 1 : TIMEOUT + 1;
          e.acc_cyc = cyc;
          sb.push_back(e);
          glog.push_back(e.port);
          lat_is_data = d_req_accept;
          lat_addr    = if_req_accept ? if_req_addr : d_req_addr;
          lat_wen     = d_req_accept && d_req_w_enable;
          lat_wdata   = d_req_w_data;
          lat_width   = d_req_w_width;
        end
      end
    end
  end

  task automatic do_fetch(input logic [31:0] a);
    bit done = 1'b0;
    if_req_addr  = a;
    if_req_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clock); #1;
      done = if_resp_valid;
    end
    if_req_valid = 1'b0;
    check("fetch_completes", {31'b0, done}, 32'd1);
  endtask

  task automatic do_data(input logic [31:0] a, input logic wen, input logic [31:0] wd,
                         input write_width_t w);
    bit done = 1'b0;
    d_req_addr     = a;
    d_req_w_enable = wen;
    d_req_w_data   = wd;
    d_req_w_width  = w;
    d_req_valid    = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clock); #1;
      done = d_resp_valid;
    end
    d_req_valid = 1'b0;
    check("data_completes", {31'b0, done}, 32'd1);
  endtask

  task automatic check_log(input string name, input arb_port_t first, input arb_port_t second);
    check({name, "_count"}, glog.size(), 2);
    if (glog.size() >= 2) begin
      check({name, "_first"}, 32'(glog[0]), 32'(first));
      check({name, "_second"}, 32'(glog[1]), 32'(second));
    end
    glog.delete();
  endtask

  task automatic contend(input logic [31:0] fa, input logic [31:0] da);
    exp_if_data = rdata_for(fa);
    exp_d_data  = rdata_for(da);
    ack_delay   = 1;
    glog.delete();
    fork
      do_fetch(fa);
      do_data(da, 1'b0, 32'h0, write_word);
    join
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 32'h0001_0000, 1'b0, 32'h0,         write_word, 1, 32'h0000_0013, 1'b0};
    vecs[1] = '{1'b1, 32'h0002_0000, 1'b0, 32'h0,         write_word, 1, 32'hFFFD_FFFF, 1'b0};
    vecs[2] = '{1'b1, 32'h0002_0010, 1'b1, 32'hDEAD_BEEF, write_word, 3, 32'h0,         1'b0};
    vecs[3] = '{1'b1, 32'h0002_0013, 1'b1, 32'h0000_00AB, write_byte, 2, 32'h0,         1'b0};
    vecs[4] = '{1'b0, 32'h0001_0008, 1'b0, 32'h0,         write_word, 4, 32'hFFFE_FFF7, 1'b0};
    vecs[5] = '{1'b1, 32'h0002_0004, 1'b0, 32'h0,         write_word, 2, 32'hFFFD_FFFB, 1'b0};
    vecs[6] = '{1'b1, 32'h0002_0008, 1'b1, 32'h0000_CAFE, write_half, 1, 32'h0,         1'b0};

    reset = 1'b1;
    if_req_valid = 1'b0; if_req_addr = '0;
    d_req_valid = 1'b0; d_req_addr = '0; d_req_w_enable = 1'b0;
    d_req_w_data = '0; d_req_w_width = write_word;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("reset_mem_req", {31'b0, mem_req}, 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_mem_w_data", mem_w_data, 32'd0);
    check("reset_mem_w_width", 32'(mem_w_width), 32'(write_word));
    check("reset_resp", {28'b0, if_resp_valid, d_resp_valid, d_resp_error, mem_w_enable}, 32'd0);
    check("reset_resp_data", if_resp_data | d_resp_data, 32'd0);

    // table-driven single transactions
    for (int i = 0; i < 7; i++) begin
      ack_delay = vecs[i].delay;
      if (vecs[i].is_data) begin
        exp_d_data = vecs[i].exp_data;
        do_data(vecs[i].addr, vecs[i].wen, vecs[i].wdata, vecs[i].width);
        check("vec_d_error", {31'b0, d_resp_error}, {31'b0, vecs[i].exp_err});
      end else begin
        exp_if_data = vecs[i].exp_data;
        do_fetch(vecs[i].addr);
      end
    end

    // reset while busy discards the transaction
    ack_en = 1'b0;
    if_req_addr = 32'h0001_0000;
    if_req_valid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("mid_busy_mem_req", {31'b0, mem_req}, 32'd1);
    reset = 1'b1;
    if_req_valid = 1'b0;
    sb.delete();
    @(posedge clock); #1;
    check("post_reset_mem_req", {31'b0, mem_req}, 32'd0);
    reset = 1'b0;
    ack_en = 1'b1;
    repeat (3) @(posedge clock);
    #1;

    // contention: fetch wins after reset and after a data grant, data wins after a fetch
    contend(32'h0001_0004, 32'h0002_0000);
    check_log("contend_reset", ARB_PORT_FETCH, ARB_PORT_DATA);
    contend(32'h0001_0004, 32'h0002_0000);
    check_log("contend_again", ARB_PORT_FETCH, ARB_PORT_DATA);
    exp_if_data = rdata_for(32'h0001_0000);
    do_fetch(32'h0001_0000);
    glog.delete();
    contend(32'h0001_0004, 32'h0002_0000);
    check_log("contend_alt", ARB_PORT_DATA, ARB_PORT_FETCH);

    // stale request held through the response cycle
    ack_delay = 1;
    exp_if_data = rdata_for(32'h0001_000C);
    if_req_addr = 32'h0001_000C;
    if_req_valid = 1'b1;
    for (int i = 0; i < 20 && !if_resp_valid; i++) begin
      @(posedge clock); #1;
    end
    #2;
    check("stale_resp_seen", {31'b0, if_resp_valid}, 32'd1);
    check("stale_no_accept", {31'b0, if_req_accept}, 32'd0);
    @(posedge clock); #3;
    check("stale_reaccept", {31'b0, if_req_accept}, 32'd1);
    #3;
    do_fetch(32'h0001_000C);

    // watchdog on a store that never acks, with a fetch queued behind it
    ack_en = 1'b0;
    exp_if_data = rdata_for(32'h0001_0004);
    glog.delete();
    fork
      do_data(32'h1000_0000, 1'b1, 32'h0000_0055, write_word);
      begin
        repeat (5) @(posedge clock);
        #1 do_fetch(32'h0001_0004);
      end
      begin
        for (int i = 0; i < 100 && !d_resp_valid; i++) begin
          @(posedge clock); #1;
        end
        ack_en = 1'b1;
      end
    join
    check_log("watchdog_order", ARB_PORT_DATA, ARB_PORT_FETCH);

    // mem_ack while idle is ignored
    stray_ack = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
      check("stray_ack_idle", {30'b0, mem_req, if_resp_valid | d_resp_valid}, 32'd0);
    end
    stray_ack = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
